mem_completion_config: RTL

- Return path of the host memory-buffer configuration: per-stream completion queues that record which enqueued buffers a stream has finished with, and how many bytes it used.
- Streams push completion records (vaddr, bytes); the host drains them by polling the config read bus.
- Sits beside the buffer-descriptor config block on the same config read address space, at its own base.

---
 rtl/mem_completion_config_pkg.sv | 22 ++
 rtl/mem_completion_config_if.sv | 31 +++
 rtl/mem_completion_config_completion_fifo.sv | 66 ++++++
 rtl/mem_completion_config.sv | 108 ++++++++++
 4 files changed

// File: rtl/mem_completion_config_pkg.sv
// rtl/mem_completion_config_pkg.sv - shared constants and types for the completion queues
//
// Purpose: identification value, per-stream register offsets and the stored
// completion record layout, shared by the top level and the queue sub-module.
package mem_completion_config_pkg;

  localparam logic [63:0] MEM_COMPLETION_ID = 64'h0000_4D43_504C_0100;

  localparam int REG_STATUS      = 0;
  localparam int REG_HEAD_VADDR  = 1;
  localparam int REG_POP         = 2;
  localparam int REGS_PER_STREAM = 3;

  localparam int CPL_VADDR_W = 48;
  localparam int CPL_BYTES_W = 32;

  typedef struct packed {
    logic [CPL_VADDR_W-1:0] vaddr;
    logic [CPL_BYTES_W-1:0] bytes;
  } completion_t;

endpackage

// File: rtl/mem_completion_config_if.sv
// rtl/mem_completion_config_if.sv - completion push and config read bus bundle
//
// Purpose: groups the per-stream completion handshake and the config read
// request/response signals.
// master: drives cpl_valid/cpl_vaddr/cpl_bytes and rd_req_*; observes cpl_ready, rd_rsp_*.
// slave : the completion block, opposite directions.
interface mem_completion_config_if #(
  parameter int NUM_STREAMS = 4,
  parameter int VADDR_W     = 48,
  parameter int BYTES_W     = 32,
  parameter int ADDR_W      = 8
);
  logic [NUM_STREAMS-1:0]         cpl_valid;
  logic [NUM_STREAMS-1:0]         cpl_ready;
  logic [NUM_STREAMS*VADDR_W-1:0] cpl_vaddr;
  logic [NUM_STREAMS*BYTES_W-1:0] cpl_bytes;
  logic                           rd_req_valid;
  logic [ADDR_W-1:0]              rd_req_addr;
  logic                           rd_rsp_valid;
  logic [63:0]                    rd_rsp_data;

  modport master (
    output cpl_valid, cpl_vaddr, cpl_bytes, rd_req_valid, rd_req_addr,
    input  cpl_ready, rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  cpl_valid, cpl_vaddr, cpl_bytes, rd_req_valid, rd_req_addr,
    output cpl_ready, rd_rsp_valid, rd_rsp_data
  );
endinterface

// File: rtl/mem_completion_config_completion_fifo.sv
// rtl/mem_completion_config_completion_fifo.sv - single-stream completion FIFO with head peek
//
// Purpose: synchronous FIFO of completion records.
// Ports: clk, rst (sync, active-high); push/wr_data enqueue; pop dequeues;
// head is the current head record (meaningful only when count != 0);
// count is occupancy (0..DEPTH); full is count == DEPTH.
module completion_fifo
  import mem_completion_config_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  completion_t              wr_data,
  input  logic                     pop,
  output completion_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;
  completion_t      mem_q [DEPTH];

  // Guard locally so count can never leave 0..DEPTH whatever the caller does.
  assign push_ok = push && (count_q != (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
endmodule

// File: rtl/mem_completion_config.sv
// rtl/mem_completion_config.sv - per-stream completion queues drained over the config read bus
//
// Purpose: streams push (vaddr, bytes) completion records into independent
// FIFOs; the host polls STATUS / HEAD_VADDR / POP registers to drain them.
// Ports: clk; rst (sync, active-high); bus (slave modport) carrying
// cpl_valid/cpl_ready/cpl_vaddr/cpl_bytes per stream and the
// rd_req_valid/rd_req_addr -> rd_rsp_valid/rd_rsp_data read path (1-cycle latency).
module mem_completion_config
  import mem_completion_config_pkg::*;
#(
  parameter int NUM_STREAMS = 4,
  parameter int DEPTH       = 64,
  parameter int VADDR_W     = CPL_VADDR_W,
  parameter int BYTES_W     = CPL_BYTES_W,
  parameter int ADDR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_completion_config_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_STREAMS-1:0] push, pop, full;
  logic [NUM_STREAMS-1:0] sel_status, sel_head, sel_pop;
  logic [NUM_STREAMS-1:0] ovf_q, ovf_d, emp_q, emp_d;
  logic [CNT_W-1:0]       cnt  [NUM_STREAMS];
  completion_t            head [NUM_STREAMS];
  logic                   rsp_valid_q, rsp_valid_d;
  logic [63:0]            rsp_data_q, rsp_data_d;

  // Ready comes from registered occupancy only; held low during reset.
  assign bus.cpl_ready = {NUM_STREAMS{~rst}} & ~full;

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_q
    completion_t wr_data;
    assign wr_data.vaddr = bus.cpl_vaddr[g*VADDR_W +: VADDR_W];
    assign wr_data.bytes = bus.cpl_bytes[g*BYTES_W +: BYTES_W];

    completion_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[g]),
      .wr_data (wr_data),
      .pop     (pop[g]),
      .head    (head[g]),
      .count   (cnt[g]),
      .full    (full[g])
    );
  end

  always_comb begin
    sel_status = '0;
    sel_head   = '0;
    sel_pop    = '0;
    push       = '0;
    pop        = '0;
    ovf_d      = '0;
    emp_d      = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      sel_status[i] = bus.rd_req_valid &&
          (bus.rd_req_addr == ADDR_W'(1 + REGS_PER_STREAM*i + REG_STATUS));
      sel_head[i]   = bus.rd_req_valid &&
          (bus.rd_req_addr == ADDR_W'(1 + REGS_PER_STREAM*i + REG_HEAD_VADDR));
      sel_pop[i]    = bus.rd_req_valid &&
          (bus.rd_req_addr == ADDR_W'(1 + REGS_PER_STREAM*i + REG_POP));
      push[i] = bus.cpl_valid[i] && bus.cpl_ready[i];
      pop[i]  = sel_pop[i] && (cnt[i] != '0);
      // New events beat the clear-on-read so none is lost.
      ovf_d[i] = (ovf_q[i] && !sel_status[i]) || (bus.cpl_valid[i] && full[i]);
      emp_d[i] = (emp_q[i] && !sel_status[i]) || (sel_pop[i] && (cnt[i] == '0));
    end
  end

  always_comb begin
    rsp_valid_d = bus.rd_req_valid;
    rsp_data_d  = rsp_data_q;
    if (bus.rd_req_valid) begin
      rsp_data_d = '0;
      if (bus.rd_req_addr == '0) rsp_data_d = MEM_COMPLETION_ID;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (sel_status[i]) begin
          rsp_data_d[15:0] = 16'(cnt[i]);
          rsp_data_d[32]   = ovf_q[i];
          rsp_data_d[33]   = emp_q[i];
        end
        if (sel_head[i] && (cnt[i] != '0)) rsp_data_d = 64'(head[i].vaddr);
        if (sel_pop[i]  && (cnt[i] != '0)) rsp_data_d = 64'(head[i].bytes);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q       <= '0;
      emp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ovf_q       <= ovf_d;
      emp_q       <= emp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_data  = rsp_data_q;
endmodule
